bicubic_bmp_reader: RTL and testbench

BICUBIC_BMP_READER -- requirements
Module: bicubic_bmp_reader

---
 rtl/bicubic_bmp_reader_pkg.sv | 16 +
 rtl/bicubic_bmp_reader_if.sv | 15 +
 rtl/dffl.sv | 15 +
 rtl/dfflr.sv | 17 +
 rtl/bicubic_bmp_reader.sv | 71 +++++++
 tb/tb_bicubic_bmp_reader.sv | 141 ++++++++++++++
 6 files changed

// File: rtl/bicubic_bmp_reader_pkg.sv
// Shared constants for the bicubic source-image reader: default source
// geometry and pixel layout used by every file of this block.
package bicubic_bmp_reader_pkg;

  localparam int SRC_IMG_WIDTH  = 960;
  localparam int SRC_IMG_HEIGHT = 540;
  localparam int PIX_DW         = 24;

  // Byte order of a stored pixel: blue in the top byte, red in the bottom.
  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pix_t;

endpackage

// File: rtl/bicubic_bmp_reader_if.sv
// Valid/ready pixel stream from the reader (master) to its consumer (slave),
// plus the end-of-frame flag.
interface bicubic_bmp_reader_if
  import bicubic_bmp_reader_pkg::*;
#(
  parameter int DW = PIX_DW
);
  logic          ready;
  logic          valid;
  logic [DW-1:0] data;
  logic          done;

  modport master (input ready, output valid, output data, output done);
  modport slave  (output ready, input valid, input data, input done);
endinterface

// File: rtl/dffl.sv
// Shared flop primitive: load enable, no reset.
module dffl #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  // Register d_i when loaded.
  always_ff @(posedge clk) begin
    // NOTE: no reset on the datapath register; its content is qualified by valid, and it is refilled while reset is held.
    if (ld_i) q_o <= d_i;
  end
endmodule

// File: rtl/dfflr.sv
// Shared flop primitive: load enable with synchronous active-high reset to 0.
module dfflr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  // Register d_i when loaded; clear on reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values, regardless of block evaluation order.
    if (rst_i)     q_o <= '0;
    else if (ld_i) q_o <= d_i;
  end
endmodule

// File: rtl/bicubic_bmp_reader.sv
// Streams one edge-padded copy of a ROM image for a bicubic scaler: one
// replicated leading row/column and two replicated trailing rows/columns,
// raster order, one pixel per cycle under sustained ready.
module bicubic_bmp_reader
  import bicubic_bmp_reader_pkg::*;
#(
  parameter int    IMG_W    = SRC_IMG_WIDTH,
  parameter int    IMG_H    = SRC_IMG_HEIGHT,
  parameter string MEM_FILE = "img.hex",
  parameter int    DW       = PIX_DW
) (
  input logic                  clk,
  input logic                  rst_n,   // synchronous, active high
  bicubic_bmp_reader_if.master io
);
  localparam int CW   = $clog2(IMG_W + 3);
  localparam int RW   = $clog2(IMG_H + 3);
  localparam int AW   = $clog2(IMG_W * IMG_H);
  localparam int NPIX = IMG_W * IMG_H;

  // Image ROM, raster order, row 0 first; contents are supplied by the environment.
  logic [DW-1:0] rom [NPIX];

  logic [CW-1:0] col_q, col_d, fetch_col;
  logic [RW-1:0] row_q, row_d, fetch_row;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [DW-1:0] data_q, data_d;
  logic          xfer, last_col, last_pix, cnt_ld, data_ld;
  logic [AW-1:0] addr;
  int            srow, scol;

  // Next-position, clamp/address and handshake decode.
  always_comb begin
    // NOTE: every variable is fully assigned on every pass, so no latches are inferred.
    last_col = (col_q == CW'(IMG_W + 2));
    last_pix = last_col && (row_q == RW'(IMG_H + 2));
    xfer     = valid_q && io.ready;
    // The final transfer freezes the counters on the last pixel.
    cnt_ld   = xfer && !last_pix;
    col_d    = last_col ? '0 : col_q + 1'b1;
    row_d    = last_col ? row_q + 1'b1 : row_q;
    valid_d  = !done_q && !(xfer && last_pix);
    done_d   = done_q || (xfer && last_pix);

    // While reset is held, prefetch padded (0,0) so it is ready on release.
    fetch_row = rst_n ? '0 : row_d;
    fetch_col = rst_n ? '0 : col_d;
    data_ld   = rst_n || cnt_ld;

    srow = int'(fetch_row) - 1;
    if (srow < 0)              srow = 0;
    else if (srow > IMG_H - 1) srow = IMG_H - 1;
    scol = int'(fetch_col) - 1;
    if (scol < 0)              scol = 0;
    else if (scol > IMG_W - 1) scol = IMG_W - 1;

    addr   = AW'(srow * IMG_W + scol);
    data_d = rom[addr];
  end

  dfflr #(.W(CW)) u_col   (.clk(clk), .rst_i(rst_n), .ld_i(cnt_ld), .d_i(col_d),   .q_o(col_q));
  dfflr #(.W(RW)) u_row   (.clk(clk), .rst_i(rst_n), .ld_i(cnt_ld), .d_i(row_d),   .q_o(row_q));
  dfflr #(.W(1))  u_valid (.clk(clk), .rst_i(rst_n), .ld_i(1'b1),   .d_i(valid_d), .q_o(valid_q));
  dfflr #(.W(1))  u_done  (.clk(clk), .rst_i(rst_n), .ld_i(1'b1),   .d_i(done_d),  .q_o(done_q));
  dffl  #(.W(DW)) u_data  (.clk(clk),                .ld_i(data_ld), .d_i(data_d), .q_o(data_q));

  assign io.valid = valid_q;
  assign io.data  = data_q;
  assign io.done  = done_q;
endmodule

// File: tb/tb_bicubic_bmp_reader.sv
// Self-checking bench for bicubic_bmp_reader on a 4x3 image: directed
// ready patterns, mid-frame reset, and random images with random ready.
module tb_bicubic_bmp_reader;
  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int DW    = 24;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int FRAME = (IMG_W + 3) * (IMG_H + 3);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [DW-1:0] img [NPIX];
  logic [DW-1:0] exp_q [$];

  bicubic_bmp_reader_if #(.DW(DW)) bus ();

  bicubic_bmp_reader #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .MEM_FILE(""), .DW(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Reference: padded frame built directly from the replication rule.
  function automatic void build_expected();
    exp_q.delete();
    for (int r = 0; r < IMG_H + 3; r++)
      for (int c = 0; c < IMG_W + 3; c++)
        exp_q.push_back(img[clampi(r - 1, 0, IMG_H - 1) * IMG_W + clampi(c - 1, 0, IMG_W - 1)]);
  endfunction

  task automatic load_rom();
    for (int i = 0; i < NPIX; i++) dut.rom[i] = img[i];
  endtask

  task automatic do_reset();
    bus.ready = 1'b0;
    rst_n     = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_valid_done", {bus.valid, bus.done}, 2'b00);
    end
    rst_n = 1'b0;
  endtask

  // mode 0: ready high, 1: toggling starting high, 2: random.
  task automatic stream(input int mode, input int stall_first, input int n_xfer);
    int            n       = 0;
    int            cyc     = 0;
    logic          stalled = 1'b0;
    logic [DW-1:0] held    = '0;
    logic          r;
    while (n < n_xfer && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stalled) check("stall_hold", bus.data, held);
      check("valid_done", {bus.valid, bus.done}, 2'b10);
      check($sformatf("pixel[%0d]", n), bus.data, exp_q[n]);
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2) == 1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (cyc <= stall_first) r = 1'b0;
      bus.ready = r;
      stalled   = !r;
      held      = bus.data;
      if (r) n++;
    end
    if (n < n_xfer) check("stream_timeout", n, n_xfer);
    if (mode == 0 && stall_first == 0) check("stream_cycles", cyc, n_xfer);
  endtask

  task automatic check_done(input int cycles);
    bus.ready = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("frame_done", {bus.valid, bus.done}, 2'b01);
    end
  endtask

  initial begin
    bus.ready = 1'b0;
    for (int i = 0; i < NPIX; i++) img[i] = DW'(16 * (i / IMG_W) + (i % IMG_W));
    load_rom();
    build_expected();

    // Full frame at one pixel per cycle, then done held with ready high.
    do_reset();
    stream(0, 0, FRAME);
    check_done(21);

    // Ready toggling every cycle.
    do_reset();
    stream(1, 0, FRAME);
    check_done(3);

    // Ready low for the first 10 cycles after reset.
    do_reset();
    stream(0, 10, FRAME);
    check_done(2);

    // Reset after 17 transfers aborts the frame; restart from padded (0,0).
    do_reset();
    stream(0, 0, 17);
    @(negedge clk);
    check("pre_abort_pixel", bus.data, exp_q[17]);
    do_reset();
    stream(0, 0, FRAME);
    check_done(2);

    // Random images with random ready.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NPIX; i++) img[i] = DW'($urandom);
      load_rom();
      build_expected();
      do_reset();
      stream(2, 0, FRAME);
      check_done(3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
